vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA timing generator; successor to the fixed 800x600 timing block. It produces registered horizontal/vertical counters, sync, blanking and data-enable signals for any mode given by porch/sync parameters, with a pixel clock enable and sync polarity control. It also provides start-of-frame, end-of-line and frame-count outputs. It sits at the head of the video pipeline and drives the timing interface consumed by the background, sprite and overlay stages.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- HSYNC_POL, 1, hsync active level
- VSYNC_POL, 1, vsync active level
- CNT_W, 11, width of hcount/vcount
- FRAME_W, 16, width of frame_cnt
- clk  in  1  pixel-domain clock
- rst  in  1  synchronous, active-high reset
- en  in  1  pixel enable; timing advances only on clk edges with en=1
- hcount  out  CNT_W  current pixel column, 0..HT-1
- vcount  out  CNT_W  current line, 0..VT-1
- hsync  out  1  horizontal sync at HSYNC_POL when active
- vsync  out  1  vertical sync at VSYNC_POL when active
- hblnk  out  1  horizontal blank
- vblnk  out  1  vertical blank
- de  out  1  data enable, equal to ~hblnk & ~vblnk
- sof  out  1  high while position is (0,0)
- eol  out  1  high while hcount = HT-1
- frame_cnt  out  FRAME_W  completed-frame counter
- line_cmp  in  CNT_W  line-compare value (only with VGA_TIMING_LINE_IRQ_EN)
- line_hit  out  1  line-compare hit (only with VGA_TIMING_LINE_IRQ_EN)

## Operation
- HT = H_ACTIVE+H_FP+H_SYNC+H_BP (1056 by default); VT = V_ACTIVE+V_FP+V_SYNC+V_BP (628 by default).
- Elaboration fails via $error if 2^CNT_W < max(HT,VT) or if any porch or sync parameter is 0.
- On an enabled edge: hcount increments. At HT-1 it wraps to 0 and vcount increments. At (HT-1,VT-1) both wrap to 0 and frame_cnt increments, wrapping modulo 2^FRAME_W.
- All other outputs are registered together with the counters and are pure functions of the registered position (h,v):
  - hblnk = h >= H_ACTIVE
  - hsync active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vblnk = v >= V_ACTIVE
  - vsync active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC
  - sync output level = active ? POL : ~POL
- vblnk and vsync therefore change only on the edge where hcount becomes 0.
- With en=0, every output holds its value. sof, eol and line_hit stay high for as many clk cycles as the position is held.
- Reset values: hcount=0, vcount=0, hblnk=0, vblnk=0, de=1, sof=1, eol=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, frame_cnt=0, line_hit=(line_cmp==0).
- rst has priority over en. Reset mid-frame returns to (0,0) on the next edge and does not increment frame_cnt.

## Timing
- Outputs reflect the registered position with zero extra latency; there is no combinational path from inputs to outputs.
- Exception: with the macro, line_hit is combinational from line_cmp. It is high when hcount==0 and vcount==line_cmp, and is never high if line_cmp >= VT.
- One enabled edge advances exactly one pixel. Frame period = HT*VT enabled edges.

## Configuration
- VGA_TIMING_LINE_IRQ_EN defined: the line_cmp/line_hit ports exist and implement a raster-line compare, used by the game logic to trigger per-line updates.
- Not defined: both ports are absent and no compare logic is built; all other behaviour is unchanged.

## Test plan
- Reset, then en=1 for 1056 cycles -> hcount runs 0..1055 and wraps to 0, vcount goes 0->1, eol is high only at hcount=1055.
- Default parameters, full line -> hsync=1 exactly for hcount 840..967, hblnk=1 for 800..1055, de=1 for 0..799.
- Full frame of 663168 enabled cycles -> vsync=1 for vcount 601..604, vblnk=1 for 600..627, frame_cnt 0->1, sof high again at (0,0).
- en toggling 1/0 every cycle -> counters advance on every second clk, and a frame takes 1326336 clk cycles.
- rst asserted at (500,300) -> next edge gives (0,0), sof=1, de=1, syncs inactive, frame_cnt unchanged; with HSYNC_POL=0 hsync idles at 1.
- With macro and line_cmp=10 -> line_hit=1 only at (0,10); with line_cmp=700 line_hit is never asserted across a frame.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Produces registered h/v counters, sync, blanking, data-enable, start-of-frame,
// end-of-line and a completed-frame counter from porch/sync parameters.
// Optional feature macro: VGA_TIMING_LINE_IRQ_EN adds line_cmp/line_hit, a
// raster-line compare that pulses at column 0 of the selected line.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int CNT_W     = 11,
  parameter int FRAME_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
`ifdef VGA_TIMING_LINE_IRQ_EN
  input  logic [CNT_W-1:0]   line_cmp,
  output logic               line_hit,
`endif
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               de,
  output logic               sof,
  output logic               eol,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counters must hold HT-1 / VT-1, and zero-width porches or syncs are illegal.
  if (((HT - 1) >> CNT_W) != 0 || ((VT - 1) >> CNT_W) != 0) begin : g_cnt_w_err
    $error("vga_timing_gen: CNT_W too small for HT/VT");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
  begin : g_zero_err
    $error("vga_timing_gen: porch and sync parameters must be non-zero");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VT - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0]   hcount_q, hcount_d;
  logic [CNT_W-1:0]   vcount_q, vcount_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               hblnk_q, hblnk_d;
  logic               vblnk_q, vblnk_d;
  logic               de_q, de_d;
  logic               sof_q, sof_d;
  logic               eol_q, eol_d;

  // Next raster position; holds when en is low so every register below holds too.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    frame_d  = frame_q;
    if (en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) begin
          vcount_d = '0;
          frame_d  = frame_q + FRAME_W'(1);
        end else begin
          vcount_d = vcount_q + CNT_W'(1);
        end
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
    end
  end

  // Decode the next position so the flags register in step with the counters.
  always_comb begin
    hblnk_d = (hcount_d >= H_ACT_C);
    vblnk_d = (vcount_d >= V_ACT_C);
    hsync_d = ((hcount_d >= HS_START) && (hcount_d < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = ((vcount_d >= VS_START) && (vcount_d < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
    de_d    = ~hblnk_d & ~vblnk_d;
    sof_d   = (hcount_d == '0) && (vcount_d == '0);
    eol_d   = (hcount_d == H_LAST);
  end

  // Timing state register; synchronous reset returns to (0,0) and clears frame count.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q <= '0;
      vcount_q <= '0;
      frame_q  <= '0;
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      de_q     <= 1'b1;
      sof_q    <= 1'b1;
      eol_q    <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      frame_q  <= frame_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
      de_q     <= de_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
    end
  end

  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign frame_cnt = frame_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign hblnk     = hblnk_q;
  assign vblnk     = vblnk_q;
  assign de        = de_q;
  assign sof       = sof_q;
  assign eol       = eol_q;

`ifdef VGA_TIMING_LINE_IRQ_EN
  // Compare is combinational from line_cmp; out-of-range lines can never hit.
  assign line_hit = (hcount_q == '0) && (vcount_q == line_cmp) && (line_cmp <= V_LAST);
`endif

endmodule
